// File: rtl/decoder_scan_pkg.sv
// Shared constants and helpers for the decoder_scan one-hot select decoder.
package decoder_scan_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select vector the helpers support; callers slice down to N.
    localparam int MAX_N = 256;

    function automatic logic [MAX_N-1:0] onehot(input logic [31:0] idx, input int unsigned n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx < n) v[idx[7:0]] = 1'b1;
        return v;
    endfunction

    function automatic int dwell_w(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/decoder_scan_rot_prio_find.sv
// Cyclic priority search: first set request strictly after start, wrapping modulo N.
module rot_prio_find #(
    parameter int SEL_W = 5,
    parameter int N     = 32
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] start_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o,
    output logic             wrap_o
);

    int cand;

    // The start index itself is visited last, so a lone request wraps onto itself.
    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        cand    = 0;
        for (int j = 0; j < N; j++) begin
            cand = (int'(start_i) + 1 + j) % N;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = SEL_W'(cand);
            end
        end
        wrap_o = found_o && (idx_o <= start_i);
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct and round-robin scan modes.
// Define DECODER_SCAN_MASK_EN to add the per-line Mask input and masked-line skipping.
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W = 5,
    parameter int N     = 32,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             En,
    input  logic             Mode,
    input  logic [SEL_W-1:0] X,
    input  logic             Load,
`ifdef DECODER_SCAN_MASK_EN
    input  logic [N-1:0]     Mask,
`endif
    output logic [N-1:0]     Y,
    output logic [SEL_W-1:0] Idx,
    output logic             Valid,
    output logic             Wrap
);

    localparam int DWELL_W = dwell_w(DWELL);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               shown_q, shown_d;
    logic [N-1:0]       y_q, y_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;

    logic [SEL_W-1:0]   nxt_idx;
    logic               nxt_wrap;
    logic               show;
    logic [MAX_N-1:0]   oh_full;

`ifdef DECODER_SCAN_MASK_EN
    logic [N-1:0]       avail;
    logic [SEL_W-1:0]   f_idx;
    logic               f_found, f_wrap;

    assign avail = ~Mask;

    rot_prio_find #(.SEL_W(SEL_W), .N(N)) u_find (
        .req_i   (avail),
        .start_i (idx_q),
        .idx_o   (f_idx),
        .found_o (f_found),
        .wrap_o  (f_wrap)
    );

    // With every line masked the index parks where it is.
    assign nxt_idx  = f_found ? f_idx : idx_q;
    assign nxt_wrap = f_found & f_wrap;
`else
    assign nxt_idx  = (int'(idx_q) >= N - 1) ? '0 : idx_q + SEL_W'(1);
    assign nxt_wrap = (nxt_idx <= idx_q);
`endif

    // shown_q marks that the current scan line has already been put on Y, so the
    // first scan cycle after reset or direct mode counts as dwell slot 0.
    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        shown_d = shown_q;
        wrap_d  = 1'b0;
        show    = 1'b0;
        if (!En) begin
            show = 1'b0;
        end else if (Mode == MODE_DIRECT) begin
            idx_d   = X;
            dwell_d = '0;
            shown_d = 1'b0;
            show    = 1'b1;
        end else if (Load) begin
            idx_d   = (int'(X) < N) ? X : '0;
            dwell_d = '0;
            shown_d = 1'b1;
            show    = 1'b1;
        end else if (!shown_q) begin
            shown_d = 1'b1;
            show    = 1'b1;
        end else if (dwell_q != DWELL_LAST) begin
            dwell_d = dwell_q + DWELL_W'(1);
            show    = 1'b1;
        end else begin
            dwell_d = '0;
            idx_d   = nxt_idx;
            wrap_d  = nxt_wrap;
            show    = 1'b1;
        end
    end

    assign oh_full = onehot(32'(idx_d), N);

    always_comb begin
        y_d = show ? oh_full[N-1:0] : '0;
`ifdef DECODER_SCAN_MASK_EN
        y_d = y_d & ~Mask;
`endif
        valid_d = |y_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            dwell_q <= '0;
            shown_q <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            shown_q <= shown_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Y     = y_q;
    assign Idx   = idx_q;
    assign Valid = valid_q;
    assign Wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: direct decode, scan sequencing, Load, En hold, async reset.
module tb_decoder_scan;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // A: N=32 direct
    logic       a_en = 0, a_mode = 0, a_load = 0;
    logic [4:0] a_x = '0;
    logic [31:0] a_y; logic [4:0] a_idx; logic a_valid, a_wrap;
    // B: N=20 direct, out-of-range index
    logic       b_en = 0, b_mode = 0, b_load = 0;
    logic [4:0] b_x = '0;
    logic [19:0] b_y; logic [4:0] b_idx; logic b_valid, b_wrap;
    // C: N=8 DWELL=4 scan
    logic       c_en = 0, c_mode = 0, c_load = 0;
    logic [2:0] c_x = '0;
    logic [7:0] c_y; logic [2:0] c_idx; logic c_valid, c_wrap;

    decoder_scan #(.SEL_W(5), .N(32), .DWELL(4)) u_a (
        .clk(clk), .rst_n(rst_n), .En(a_en), .Mode(a_mode), .X(a_x), .Load(a_load),
`ifdef DECODER_SCAN_MASK_EN
        .Mask(32'h0),
`endif
        .Y(a_y), .Idx(a_idx), .Valid(a_valid), .Wrap(a_wrap));

    decoder_scan #(.SEL_W(5), .N(20), .DWELL(4)) u_b (
        .clk(clk), .rst_n(rst_n), .En(b_en), .Mode(b_mode), .X(b_x), .Load(b_load),
`ifdef DECODER_SCAN_MASK_EN
        .Mask(20'h0),
`endif
        .Y(b_y), .Idx(b_idx), .Valid(b_valid), .Wrap(b_wrap));

    decoder_scan #(.SEL_W(3), .N(8), .DWELL(4)) u_c (
        .clk(clk), .rst_n(rst_n), .En(c_en), .Mode(c_mode), .X(c_x), .Load(c_load),
`ifdef DECODER_SCAN_MASK_EN
        .Mask(8'h0),
`endif
        .Y(c_y), .Idx(c_idx), .Valid(c_valid), .Wrap(c_wrap));

`ifdef DECODER_SCAN_MASK_EN
    // D: N=8 DWELL=1 masked scan
    logic       d_en = 0, d_mode = 0, d_load = 0;
    logic [2:0] d_x = '0;
    logic [7:0] d_mask = '0;
    logic [7:0] d_y; logic [2:0] d_idx; logic d_valid, d_wrap;

    decoder_scan #(.SEL_W(3), .N(8), .DWELL(1)) u_d (
        .clk(clk), .rst_n(rst_n), .En(d_en), .Mode(d_mode), .X(d_x), .Load(d_load),
        .Mask(d_mask), .Y(d_y), .Idx(d_idx), .Valid(d_valid), .Wrap(d_wrap));
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_y;

        // Reset state
        tick(); tick();
        chk("rst_a_y", a_y, 0);
        chk("rst_c_y", c_y, 0);
        chk("rst_c_idx", c_idx, 0);
        chk("rst_c_valid", c_valid, 0);
        chk("rst_c_wrap", c_wrap, 0);
        rst_n = 1'b1;
        tick();

        // Direct decode on N=32
        a_en = 1; a_mode = 0; a_x = 5'd5;
        tick();
        chk("a_x5_y", a_y, 32'h0000_0020);
        chk("a_x5_valid", a_valid, 1);
        chk("a_x5_idx", a_idx, 5);
        a_x = 5'd31;
        tick();
        chk("a_x31_y", a_y, 32'h8000_0000);
        a_en = 0;
        tick();
        chk("a_en0_y", a_y, 0);
        chk("a_en0_valid", a_valid, 0);
        chk("a_en0_idx", a_idx, 31);

        // Direct decode, index beyond N=20
        b_en = 1; b_mode = 0; b_x = 5'd25;
        tick();
        chk("b_x25_y", b_y, 0);
        chk("b_x25_valid", b_valid, 0);
        chk("b_x25_idx", b_idx, 25);
        b_x = 5'd19;
        tick();
        chk("b_x19_y", b_y, 20'h8_0000);
        b_en = 0;

        // Scan from reset: each line for 4 cycles, line 0 returns at cycle 33
        c_en = 1; c_mode = 1; c_load = 0;
        for (int t = 1; t <= 32; t++) begin
            tick();
            exp_y = 8'h01 << ((t - 1) / 4);
            chk($sformatf("scan_y_%0d", t), c_y, exp_y);
            chk($sformatf("scan_wrap_%0d", t), c_wrap, 0);
        end
        tick();
        chk("scan_y_33", c_y, 8'h01);
        chk("scan_wrap_33", c_wrap, 1);
        tick();
        chk("scan_y_34", c_y, 8'h01);
        chk("scan_wrap_34", c_wrap, 0);

        // Load X=6 while dwell is 2
        tick();
        c_load = 1; c_x = 3'd6;
        tick();
        c_load = 0;
        chk("load6_y", c_y, 8'h40);
        chk("load6_idx", c_idx, 6);
        chk("load6_wrap", c_wrap, 0);
        for (int t = 2; t <= 8; t++) begin
            tick();
            exp_y = (t <= 4) ? 8'h40 : 8'h80;
            chk($sformatf("load6_seq_%0d", t), c_y, exp_y);
        end
        tick();
        chk("load6_ret_y", c_y, 8'h01);
        chk("load6_ret_wrap", c_wrap, 1);

        // Load coinciding with dwell expiry: Load wins, no Wrap
        tick(); tick(); tick();
        chk("pre_coll_y", c_y, 8'h01);
        c_load = 1; c_x = 3'd3;
        tick();
        c_load = 0;
        chk("coll_y", c_y, 8'h08);
        chk("coll_idx", c_idx, 3);
        chk("coll_wrap", c_wrap, 0);

        // En low mid-dwell, then resume with remaining dwell
        tick();
        c_en = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1 || t == 10) begin
                chk($sformatf("hold_y_%0d", t), c_y, 0);
                chk($sformatf("hold_valid_%0d", t), c_valid, 0);
            end
        end
        chk("hold_idx", c_idx, 3);
        c_en = 1;
        tick();
        chk("resume_y1", c_y, 8'h08);
        tick();
        chk("resume_y2", c_y, 8'h08);
        tick();
        chk("resume_next", c_y, 8'h10);

        // Asynchronous reset mid-scan
        tick();
        rst_n = 1'b0;
        #2;
        chk("arst_y", c_y, 0);
        chk("arst_idx", c_idx, 0);
        chk("arst_valid", c_valid, 0);
        chk("arst_wrap", c_wrap, 0);
        tick();
        rst_n = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            exp_y = (t <= 4) ? 8'h01 : 8'h02;
            chk($sformatf("post_rst_%0d", t), c_y, exp_y);
        end

`ifdef DECODER_SCAN_MASK_EN
        // Masked scan on lines 1 and 3 only
        d_mask = 8'hF5; d_en = 1; d_mode = 1;
        tick();
        chk("mask_prime_y", d_y, 0);
        tick();
        chk("mask_y1", d_y, 8'h02);
        chk("mask_w1", d_wrap, 0);
        tick();
        chk("mask_y2", d_y, 8'h08);
        chk("mask_w2", d_wrap, 0);
        tick();
        chk("mask_y3", d_y, 8'h02);
        chk("mask_w3", d_wrap, 1);
        tick();
        chk("mask_y4", d_y, 8'h08);
        d_mask = 8'hFF;
        tick();
        chk("mask_all_y", d_y, 0);
        chk("mask_all_valid", d_valid, 0);
        chk("mask_all_wrap", d_wrap, 0);
        chk("mask_all_idx", d_idx, 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered one-hot decoder with an auto-scan mode, successor to the 5-to-32 enable decoder. In direct mode it decodes a binary index to N select lines. In scan mode it steps the active line round-robin, holding each line for a fixed dwell period. It sits between board control logic and multiplexed loads (digit strobes, LED columns, row selects) in the lab designs.

## Interface
- `SEL_W`, default 5: index width.
- `N`, default 32: number of select lines; 2 ≤ N ≤ 2^SEL_W.
- `DWELL`, default 4: cycles each line stays active in scan mode; ≥ 1.
- `clk`  in  1: clock, rising edge. One clock only.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `En`  in  1: enable. Low forces Y to 0 and freezes scan state.
- `Mode`  in  1: 0 = direct, 1 = scan.
- `X`  in  SEL_W: direct index; scan start index on `Load`.
- `Load`  in  1: scan mode only; loads `X` as the current index.
- `Mask`  in  N: per-line disable; present only with `DECODER_SCAN_MASK_EN`.
- `Y`  out  N: registered one-hot select, or all zero.
- `Idx`  out  SEL_W: registered current index.
- `Valid`  out  1: registered; high iff Y is non-zero.
- `Wrap`  out  1: registered one-cycle pulse when the scan index wraps to a lower value.

## Operation
- State: `idx_q` (SEL_W), `dwell_q` (counts 0..DWELL-1), output registers Y/Valid/Wrap.
- Direct mode (`Mode`=0):
  - `idx_q` ← X and `dwell_q` ← 0 every cycle.
  - Y ← 1<<X when En=1 and X<N; otherwise Y ← 0.
- Scan mode (`Mode`=1, `En`=1):
  - `Load`=1: `idx_q` ← X if X<N, else 0; `dwell_q` ← 0. `Load` has priority over dwell advance.
  - Otherwise, `dwell_q`<DWELL-1: `dwell_q` increments.
  - Otherwise (`dwell_q`=DWELL-1): `dwell_q` ← 0 and `idx_q` advances to the next index modulo N.
  - Wrap ← 1 when an advance produces a new index ≤ the old one (e.g. N-1→0).
  - Y ← 1<<`idx_q`(next).
- `En`=0, either mode: Y ← 0, Valid ← 0, Wrap ← 0. `idx_q` and `dwell_q` hold. `Load` is ignored.
- Direct→scan switch: scanning starts from the current `idx_q` with `dwell_q`=0. Scan→direct switch: takes effect on the next edge.
- DWELL=1: the index advances every enabled cycle.
- Index arithmetic is unsigned SEL_W-bit. The wrap compare is N-1→0, not 2^SEL_W, when N is not a power of two.

## Timing
- All outputs are registered. Latency from X/En/Mode/Load to Y/Idx/Valid/Wrap is 1 cycle.
- Reset (async assert, sync-safe deassert by the system): Y=0, Idx=0, Valid=0, Wrap=0, `dwell_q`=0.
- Reset mid-scan aborts the dwell. The first post-reset scan line is 0 for the full DWELL cycles.
- Wrap is high for exactly one cycle, aligned with Idx showing the wrapped value.
- In scan mode, `Load` and dwell expiry in the same cycle: `Load` wins and Wrap=0.

## Configuration
- `DECODER_SCAN_MASK_EN` defined:
  - The `Mask` port exists.
  - Scan advance moves to the next index cyclically after `idx_q` with Mask=0, skipping masked lines.
  - Wrap is set when the found index ≤ the old index.
  - If the current line is masked (Mask changed), Y ← 0 until the next advance.
  - If all lines are masked: Y=0, Valid=0, `idx_q` holds, Wrap=0.
  - Direct mode: a masked X yields Y=0.
  - `Load` of a masked X: Y=0 for that dwell, then normal advance.
- Not defined: no `Mask` port, and every line 0..N-1 is visited.

## Structure
- Package `decoder_scan_pkg`:
  - `MODE_DIRECT`/`MODE_SCAN` constants.
  - `onehot(idx)` function returning an N-bit vector, zero for idx ≥ N.
  - `DWELL_W` = $clog2(DWELL) helper, minimum 1.
- Sub-module `rot_prio_find`, instantiated only under `DECODER_SCAN_MASK_EN`:
  - Inputs: N-bit request vector and a start index.
  - Outputs: first set index strictly after start, cyclically, plus a found flag and a wrapped flag.

## Test plan
- Direct, N=32, En=1: X=5 → next cycle Y=0x0000_0020, Valid=1. En=0 → Y=0, Valid=0.
- Direct, N=20: X=25 → Y=0, Valid=0, Idx=25.
- Scan, N=8, DWELL=4, from reset:
  - Y=0x01 for 4 cycles, then 0x02, and so on through 0x80.
  - Y=0x01 returns on cycle 33 with Wrap=1 for exactly that cycle.
- Scan, N=8, DWELL=4, Load with X=6 at dwell 2 → Y=0x40 for 4 full cycles, then 0x80, then 0x01 with Wrap=1.
- En low for 10 cycles mid-dwell → Y=0. On re-enable, the same line resumes with the remaining dwell count.
- Reset pulsed mid-scan → all outputs 0 immediately (asynchronous). Scan restarts at line 0.
- Mask, N=8, DWELL=1, `DECODER_SCAN_MASK_EN`:
  - Mask=0xF5 → sequence 0x02, 0x08, 0x02, with Wrap on each return to 1.
  - Mask=0xFF → Y=0, Valid=0.
